// File: rtl/we_reg_arbiter.sv
// Round-robin write scheduler: grants one (addr, data) write per cycle from NREQ requesters
// and drives registered one-hot write strobes, shared data, source index, error flag and write count.
module we_reg_arbiter #(
  parameter int NREQ  = 4,
  parameter int NREGS = 8,
  parameter int AW    = (NREGS > 1) ? $clog2(NREGS) : 1,
  parameter int SW    = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*32-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREGS-1:0]     wr_en,
  output logic [31:0]          wr_data,
  output logic [SW-1:0]        wr_src,
  output logic                 wr_err,
  output logic [15:0]          wr_count
);

  logic [SW-1:0]    ptr_q, ptr_d;
  logic [NREGS-1:0] wr_en_q, wr_en_d;
  logic [31:0]      wr_data_q, wr_data_d;
  logic [SW-1:0]    wr_src_q, wr_src_d;
  logic             wr_err_q, wr_err_d;
  logic [15:0]      wr_count_q, wr_count_d;

  logic             found;
  logic [SW-1:0]    win_idx;
  logic [SW-1:0]    cand_idx;
  int               cand;
  logic             grant;
  logic [AW-1:0]    win_addr;
  logic [31:0]      win_data;
  logic             in_range;

  // Rotating search: the first valid requester at or after ptr wins.
  // NOTE: every variable gets a default at the top of an always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    found    = 1'b0;
    win_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_idx = SW'(cand);
      if (!found && req_valid[cand_idx]) begin
        found   = 1'b1;
        win_idx = cand_idx;
      end
    end
  end

  assign grant     = found && rst && enable;
  assign req_ready = grant ? (NREQ'(1) << win_idx) : '0;
  assign win_addr  = req_addr[int'(win_idx)*AW +: AW];
  assign win_data  = req_data[int'(win_idx)*32 +: 32];
  assign in_range  = int'(win_addr) < NREGS;

  always_comb begin
    ptr_d      = ptr_q;
    wr_en_d    = '0;
    wr_data_d  = wr_data_q;
    wr_src_d   = wr_src_q;
    wr_err_d   = 1'b0;
    wr_count_d = wr_count_q;
    if (grant) begin
      ptr_d     = (win_idx == SW'(NREQ - 1)) ? '0 : win_idx + SW'(1);
      wr_data_d = win_data;
      wr_src_d  = win_idx;
      if (in_range) begin
        wr_en_d    = NREGS'(1) << win_addr;
        wr_count_d = wr_count_q + 16'd1;
      end else begin
        // Out-of-range writes are consumed but never reach the bank.
        wr_err_d = 1'b1;
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  // NOTE: reset is synchronous and active-low; it wins over any transfer in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q      <= '0;
      wr_en_q    <= '0;
      wr_data_q  <= '0;
      wr_src_q   <= '0;
      wr_err_q   <= 1'b0;
      wr_count_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      wr_src_q   <= wr_src_d;
      wr_err_q   <= wr_err_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_data  = wr_data_q;
  assign wr_src   = wr_src_q;
  assign wr_err   = wr_err_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_we_reg_arbiter.sv
// Scoreboard bench for we_reg_arbiter: a driver feeds directed and random stimulus and pushes
// model expectations; a negedge monitor pops and compares them against the DUT outputs.
module tb_we_reg_arbiter;
  localparam int NREQ  = 4;
  localparam int NREGS = 6;
  localparam int AW    = 3;
  localparam int SW    = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                enable = 1'b0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ*AW-1:0]  req_addr = '0;
  logic [NREQ*32-1:0]  req_data = '0;
  logic [NREQ-1:0]     req_ready;
  logic [NREGS-1:0]    wr_en;
  logic [31:0]         wr_data;
  logic [SW-1:0]       wr_src;
  logic                wr_err;
  logic [15:0]         wr_count;

  always #5 clk = ~clk;

  we_reg_arbiter #(.NREQ(NREQ), .NREGS(NREGS)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .wr_en(wr_en), .wr_data(wr_data),
    .wr_src(wr_src), .wr_err(wr_err), .wr_count(wr_count)
  );

  typedef struct {
    int              cyc;
    logic [NREQ-1:0] rdy;
  } rdy_t;

  typedef struct {
    int               cyc;
    logic [NREGS-1:0] en;
    logic [31:0]      data;
    logic [SW-1:0]    src;
    logic             err;
    logic [15:0]      cnt;
  } out_t;

  rdy_t rdy_q[$];
  out_t out_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Reference model state, kept as plain integers.
  int          m_ptr = 0;
  int          m_cnt = 0;
  int          m_src = 0;
  logic [31:0] m_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle of inputs and push what the model says should happen.
  task automatic step(input logic r, input logic e, input logic [NREQ-1:0] v,
                      input logic [NREQ*AW-1:0] a, input logic [NREQ*32-1:0] d);
    int   win;
    int   ad;
    rdy_t rq;
    out_t oq;
    @(posedge clk);
    #2;
    rst       = r;
    enable    = e;
    req_valid = v;
    req_addr  = a;
    req_data  = d;
    win = -1;
    if (r && e) begin
      for (int k = 0; k < NREQ; k++) begin
        if (win < 0 && v[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
      end
    end
    rq.cyc = cyc;
    rq.rdy = (win >= 0) ? NREQ'(1 << win) : '0;
    rdy_q.push_back(rq);
    if (!r) begin
      m_ptr  = 0;
      m_cnt  = 0;
      m_src  = 0;
      m_data = '0;
      oq.en  = '0;
      oq.err = 1'b0;
    end else if (win >= 0) begin
      ad     = int'(a[win*AW +: AW]);
      m_ptr  = (win + 1) % NREQ;
      m_data = d[win*32 +: 32];
      m_src  = win;
      if (ad < NREGS) begin
        oq.en  = NREGS'(1 << ad);
        oq.err = 1'b0;
        m_cnt  = (m_cnt + 1) % 65536;
      end else begin
        oq.en  = '0;
        oq.err = 1'b1;
      end
    end else begin
      oq.en  = '0;
      oq.err = 1'b0;
    end
    oq.cyc  = cyc + 1;
    oq.data = m_data;
    oq.src  = SW'(m_src);
    oq.cnt  = 16'(m_cnt);
    out_q.push_back(oq);
    #1;
  endtask

  rdy_t mon_r;
  out_t mon_o;

  initial begin
    forever begin
      @(negedge clk);
      if (rdy_q.size() > 0 && rdy_q[0].cyc == cyc) begin
        mon_r = rdy_q.pop_front();
        check("req_ready", 32'(req_ready), 32'(mon_r.rdy));
      end
      if (out_q.size() > 0 && out_q[0].cyc == cyc) begin
        mon_o = out_q.pop_front();
        check("wr_en", 32'(wr_en), 32'(mon_o.en));
        check("wr_data", wr_data, mon_o.data);
        check("wr_src", 32'(wr_src), 32'(mon_o.src));
        check("wr_err", 32'(wr_err), 32'(mon_o.err));
        check("wr_count", 32'(wr_count), 32'(mon_o.cnt));
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NREQ*AW-1:0] a;
    logic [NREQ*32-1:0] d;
    logic [NREGS-1:0]   prev_en;
    int                 cnt_before;

    // Reset with every requester valid: nothing may be granted.
    d = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    a = '0;
    repeat (3) begin
      step(1'b0, 1'b1, '1, a, d);
      check("rst_ready", 32'(req_ready), 32'h0);
    end
    step(1'b1, 1'b1, '1, a, d);
    check("first_grant", 32'(req_ready), 32'h1);
    check("post_rst_en", 32'(wr_en), 32'h0);
    check("post_rst_data", wr_data, 32'h0);
    check("post_rst_count", 32'(wr_count), 32'h0);

    // Single write from requester 2 to register 5.
    repeat (2) step(1'b0, 1'b1, '0, a, d);
    a = '0;
    a[2*AW +: AW] = 3'd5;
    d = '0;
    d[2*32 +: 32] = 32'hDEAD_BEEF;
    step(1'b1, 1'b1, 4'b0100, a, d);
    check("single_ready", 32'(req_ready), 32'h4);
    step(1'b1, 1'b1, '0, a, d);
    check("single_en", 32'(wr_en), 32'h20);
    check("single_data", wr_data, 32'hDEAD_BEEF);
    check("single_src", 32'(wr_src), 32'd2);
    check("single_count", 32'(wr_count), 32'd1);
    step(1'b1, 1'b1, '0, a, d);
    check("single_en_clear", 32'(wr_en), 32'h0);

    // Contention: all four valid for eight cycles after a fresh reset.
    step(1'b0, 1'b1, '0, a, d);
    prev_en = '0;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        a[i*AW +: AW] = AW'((k + i) % NREGS);
        d[i*32 +: 32] = $urandom;
      end
      step(1'b1, 1'b1, '1, a, d);
      check("ctn_grant", 32'(req_ready), 32'(1 << (k % NREQ)));
      if (k > 0) check("ctn_en", 32'(wr_en), 32'(prev_en));
      prev_en = NREGS'(1 << ((k + (k % NREQ)) % NREGS));
    end
    step(1'b1, 1'b1, '0, a, d);
    check("ctn_en_last", 32'(wr_en), 32'(prev_en));
    check("ctn_count", 32'(wr_count), 32'd8);

    // Enable gating: grant 1, freeze four cycles, then requester 2 is next.
    a = {NREQ{3'd1}};
    step(1'b1, 1'b1, 4'b0010, a, d);
    check("gate_grant1", 32'(req_ready), 32'h2);
    repeat (4) begin
      step(1'b1, 1'b0, '1, a, d);
      check("gate_ready_off", 32'(req_ready), 32'h0);
    end
    step(1'b1, 1'b1, '1, a, d);
    check("gate_next", 32'(req_ready), 32'h4);

    // Out-of-range address from requester 3.
    step(1'b1, 1'b1, '0, a, d);
    cnt_before = m_cnt;
    a = '0;
    a[3*AW +: AW] = 3'd7;
    d = '0;
    d[3*32 +: 32] = 32'h0000_1234;
    step(1'b1, 1'b1, 4'b1000, a, d);
    check("oor_ready", 32'(req_ready), 32'h8);
    step(1'b1, 1'b1, '0, a, d);
    check("oor_en", 32'(wr_en), 32'h0);
    check("oor_err", 32'(wr_err), 32'h1);
    check("oor_src", 32'(wr_src), 32'd3);
    check("oor_data", wr_data, 32'h0000_1234);
    check("oor_count", 32'(wr_count), 32'(cnt_before));

    // Reset in a cycle where a transfer would otherwise happen.
    a = {NREQ{3'd2}};
    step(1'b0, 1'b1, '1, a, d);
    check("rst_xfer_ready", 32'(req_ready), 32'h0);
    step(1'b1, 1'b1, '0, a, d);
    check("rst_xfer_en", 32'(wr_en), 32'h0);
    check("rst_xfer_count", 32'(wr_count), 32'h0);

    // Random traffic, including out-of-range addresses, enable drops and resets.
    for (int n = 0; n < 3000; n++) begin
      a = NREQ*AW'($urandom);
      d = {$urandom, $urandom, $urandom, $urandom};
      step(($urandom % 50) != 0, ($urandom % 8) != 0, NREQ'($urandom), a, d);
    end

    // Counter wrap: 65536 in-range writes from a fresh reset.
    step(1'b0, 1'b1, '0, a, d);
    for (int n = 0; n < 65536; n++) begin
      for (int i = 0; i < NREQ; i++) a[i*AW +: AW] = AW'($urandom % NREGS);
      d = {$urandom, $urandom, $urandom, $urandom};
      step(1'b1, 1'b1, '1, a, d);
    end
    step(1'b1, 1'b1, '0, a, d);
    check("wrap_count", 32'(wr_count), 32'h0);

    repeat (2) @(negedge clk);
    check("sb_drain", 32'(rdy_q.size() + out_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/we_reg_arbiter.md
# we_reg_arbiter

Round-robin write scheduler for a bank of 32-bit write-enabled registers shared by several requesters. Each requester offers an (address, data) write through a valid/ready handshake. The block grants at most one write per cycle and drives registered per-register write strobes plus a shared data bus straight into the register bank's `wr_in`/`data_in` pins. It also reports the granted source, counts completed writes and flags out-of-range addresses.

## Interface
- `NREQ`, 4: number of requesters (2..8)
- `NREGS`, 8: number of registers in the bank (1..32; need not be a power of two)
- `AW`, `$clog2(NREGS)` (min 1): register address width
- `SW`, `$clog2(NREQ)`: source index width

- `clk`  in  1  clock; all state on rising edge
- `rst`  in  1  reset, synchronous, active-low (`rst==0` resets)
- `enable`  in  1  1 = grants allowed; 0 = freeze arbitration
- `req_valid`  in  NREQ  requester i offers a write
- `req_addr`  in  NREQ*AW  requester i address at `[i*AW +: AW]`
- `req_data`  in  NREQ*32  requester i data at `[i*32 +: 32]`
- `req_ready`  out  NREQ  one-hot or zero; transfer when `req_valid[i] && req_ready[i]`
- `wr_en`  out  NREGS  registered one-hot write strobe to register bank
- `wr_data`  out  32  registered write data, shared by all registers
- `wr_src`  out  SW  registered index of the requester whose write is on `wr_en`/`wr_data`
- `wr_err`  out  1  registered pulse: accepted write had `addr >= NREGS`
- `wr_count`  out  16  registered count of successful writes

## Operation
- Priority pointer `ptr` (SW bits, reset 0). Each cycle, search `req_valid` starting at index `ptr` and wrap modulo NREQ. The first set bit i is the winner.
- `req_ready[i]` is combinational and set only for the winner, and only when `rst==1 && enable==1`. It never depends on `req_ready` feedback. At most one bit is set.
- On a transfer from requester i:
  - `ptr <= (i+1) mod NREQ`.
  - The winner's addr/data are captured into the output registers.
- With no transfer, `ptr` holds.
- Output registers, updated every cycle:
  - Transfer with `addr < NREGS`:
    - `wr_en <= 1<<addr`
    - `wr_data <= data`
    - `wr_src <= i`
    - `wr_err <= 0`
    - `wr_count <= wr_count+1`, wrapping mod 2^16
  - Transfer with `addr >= NREGS`:
    - write is accepted but dropped
    - `wr_en <= 0`
    - `wr_err <= 1`
    - `wr_src <= i`
    - `wr_data <= data`
    - `wr_count` unchanged
  - No transfer:
    - `wr_en <= 0`
    - `wr_err <= 0`
    - `wr_data` and `wr_src` hold their last values
- `enable==0`: `req_ready` is all zero, `ptr` holds, and outputs follow the no-transfer rule. A write already registered still issues its strobe in the following cycle.
- Requesters must keep addr/data stable while valid and not ready. The block does not check this.
- Reset (`rst==0` at an edge):
  - `ptr=0`, `wr_en=0`, `wr_data=0`, `wr_src=0`, `wr_err=0`, `wr_count=0`.
  - `req_ready` is forced to 0 combinationally while `rst==0`.
  - Reset overrides a transfer in the same cycle; that write is lost and is not counted.

## Timing
- Cycle T: `req_valid[i] && req_ready[i]` is a transfer.
- Edge ending T: `wr_en`, `wr_data`, `wr_src`, `wr_err` and `wr_count` reflect the write during T+1.
- Edge ending T+1: the addressed register loads the data; its output shows the new value from T+2.
- Throughput is one write per cycle. `wr_en` may be high in consecutive cycles, to the same or different registers.
- Fairness: a requester that holds valid is granted within NREQ cycles of `enable` being high.
- `req_ready` has a combinational path from `req_valid`, `rst` and `enable`. There is no path from `req_addr` or `req_data` to `req_ready`.

## Test plan
- Reset: `rst=0` for 3 cycles with all `req_valid=1`.
  - Required: `req_ready=0` throughout.
  - Required: all outputs 0 through the first cycle after `rst=1`.
  - Required: first grant goes to requester 0.
- Single write: requester 2, addr 5, data 0xDEADBEEF.
  - Required: `req_ready=4'b0100` in the same cycle.
  - Required next cycle: `wr_en=8'h20`, `wr_data=0xDEADBEEF`, `wr_src=2`, `wr_count=1`.
  - Required: `wr_en=0` the cycle after.
- Contention: all 4 valid for 8 cycles.
  - Required: grant order 0,1,2,3,0,1,2,3.
  - Required: `wr_count=8`; `wr_en` high on 8 consecutive cycles.
- Enable gating: grant to requester 1, then `enable=0` for 4 cycles with all valid, then `enable=1`.
  - Required: no `req_ready` while `enable=0`.
  - Required: next grant goes to requester 2.
- Out-of-range address: `NREGS=6`, requester 3 writes addr 7 with data 0x1234.
  - Required: transfer accepted.
  - Required next cycle: `wr_en=0`, `wr_err=1`, `wr_src=3`, `wr_count` unchanged.
- Reset and wrap:
  - Assert `rst=0` in the same cycle as a transfer. Required: no strobe follows and `wr_count=0`.
  - Perform 65536 valid writes. Required: `wr_count` wraps to 0.
